mem_readback_streamer: RTL and testbench
========================================

Name: mem_readback_streamer

Overview:
- Read-side counterpart to the block-RAM wrapper. That wrapper is loaded by its init file and written through waddr/din; this block reads a window of the RAM back out.
- It drives the RAM's raddr port and absorbs the RAM's fixed 1-cycle registered read latency.
- It emits each word as a valid/ready stream beat tagged with its address, and keeps a running checksum.
- Use: post-reconfiguration checks that memory contents match the expected init image.

Parameters:
WID_MEM, 16, data width of the attached RAM and of the output stream.
DEPTH_MEM, 4096, number of RAM words; read addresses wrap modulo DEPTH_MEM.
FIFO_DEPTH, 4, output buffer entries; minimum 4, needed for 1 beat/cycle with 2 reads in flight.

Ports:
clk  input  1  sole clock; all logic is on its rising edge.
reset  input  1  synchronous, active-low reset (0 = reset).
start  input  1  1-cycle request; sampled only when busy=0.
rd_base  input  32  first word address; captured on an accepted start.
rd_len  input  32  number of words to read; captured on an accepted start.
raddr  output  32  read address to the RAM.
rdata  input  WID_MEM  RAM dout; valid 1 cycle after raddr is presented.
m_valid  output  1  output beat valid.
m_ready  input  1  downstream accept.
m_data  output  WID_MEM  beat data.
m_addr  output  32  RAM address the beat was read from.
busy  output  1  sweep in progress.
done  output  1  1-cycle pulse at sweep completion.
checksum  output  32  wrapping sum of the accepted beats in the current or last sweep.

Behaviour:
- Reset (reset=0 on a clock edge): every output goes to 0, including raddr, m_data, m_addr and checksum. The FIFO and all in-flight reads are discarded, and the state goes to IDLE. This applies mid-sweep as well; there is no partial completion and no done pulse.
- States:
  - IDLE -> RUN when start=1 and rd_len!=0.
  - IDLE -> FINISH when start=1 and rd_len=0.
  - RUN -> DRAIN once all rd_len reads have been issued.
  - DRAIN -> FINISH when the last beat is accepted.
  - FINISH -> IDLE unconditionally, 1 cycle. done=1 only during FINISH.
- Accepted start: checksum is cleared to 0, and rd_base and rd_len are captured.
- start while busy: ignored, no side effects.
- busy is 1 in RUN and DRAIN, 0 in IDLE and FINISH.
- Issue: a read is issued in a cycle when state=RUN, issued<rd_len, and fifo_count + in_flight < FIFO_DEPTH.
  - in_flight counts reads issued but not yet written into the FIFO (0..2).
  - raddr holds the last issued address when no read is issued; the RAM reads every cycle, but the result is discarded unless tagged.
- Address sequence: rd_base mod DEPTH_MEM, then +1 per issue. After DEPTH_MEM-1 the next address is 0.
- Latency:
  - start sampled in cycle 0.
  - raddr = first address in cycle 1.
  - rdata valid in cycle 2; the tagged word is written into the FIFO at the end of cycle 2.
  - m_valid=1 from cycle 3.
- Throughput: with m_ready held at 1, one beat per cycle is sustained. There are no bubbles after the first beat.
- Stream rules:
  - m_data and m_addr stay stable while m_valid=1 and m_ready=0.
  - Beats come out in issue order; no drop, no duplicate.
  - m_valid deasserts only after a transfer that empties the FIFO.
- FIFO corner cases:
  - Simultaneous FIFO write and read, including at full: both take effect and the count is unchanged.
  - The FIFO never overflows because of the credit rule. An overflow attempt is a design error; the bench asserts it never occurs.
- Checksum: on each transfer (m_valid & m_ready), checksum <= checksum + zero_extend(m_data), modulo 2^32. It holds its value after done until the next accepted start.
- Completion: done fires the cycle after the transfer of the rd_len-th beat, or the cycle after start when rd_len=0. A new start is accepted in the FINISH cycle's successor.
- rd_len > DEPTH_MEM is legal: addresses keep wrapping and words repeat.

Test Plan:
- Setup: RAM init with word i = i (16x4K).
- Streaming: rd_base=0, rd_len=8, m_ready=1 -> m_valid first in cycle 3; m_addr/m_data 0..7 on 8 consecutive cycles; done 1 cycle after the last beat; checksum=28.
- Backpressure: rd_base=0, rd_len=16, m_ready toggling 1,0,1,0 (plus a 10-cycle m_ready=0 stall) -> 16 beats in order, stable data during stalls, no overflow; checksum=120.
- Wrap: rd_base=4094, rd_len=4 -> m_addr 4094, 4095, 0, 1; m_data identical to m_addr; checksum=8190.
- Zero length: rd_len=0 -> no m_valid, busy stays 0, done pulse 1 cycle after start, checksum=0.
- Busy start: start pulsed with rd_base=100 during the first sweep -> ignored; stream and checksum unchanged.
- Reset mid-sweep: reset=0 after 5 beats with m_ready=0 and the FIFO full -> next cycle m_valid=0, busy=0, checksum=0, no done. Then rd_base=0, rd_len=2 -> beats 0, 1; checksum=1.

Source files
------------

// File: rtl/mem_readback_streamer_if.sv
// Output beat stream of mem_readback_streamer: one RAM word tagged with its address.
interface mem_readback_streamer_if #(
  parameter int WID_MEM = 16
) ();
  logic               m_valid;
  logic               m_ready;
  logic [WID_MEM-1:0] m_data;
  logic [31:0]        m_addr;

  modport master (output m_valid, m_data, m_addr, input m_ready);
  modport slave  (input m_valid, m_data, m_addr, output m_ready);
endinterface

// File: rtl/mem_readback_streamer.sv
// Small synchronous FIFO used as the streamer's output buffer.
// Latency: a written word is visible at the head the cycle after the write.
// Backpressure: a write at full only lands if the head is read the same cycle.
module mrs_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         wr_vld,
  input  logic [W-1:0] wr_dat,
  output logic         rd_vld,
  input  logic         rd_rdy,
  output logic [W-1:0] rd_dat,
  output logic [31:0]  count
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [31:0]   cnt_q, cnt_d;
  logic          wr_rdy, do_wr, do_rd;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (32'(p) == DEPTH - 1) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    rd_vld   = (cnt_q != 0);
    wr_rdy   = (cnt_q != 32'(DEPTH)) || rd_rdy;
    do_rd    = rd_vld && rd_rdy;
    do_wr    = wr_vld && wr_rdy;
    rd_dat   = mem_q[rd_ptr_q];
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_wr) begin
      mem_d[wr_ptr_q] = wr_dat;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (do_rd) rd_ptr_d = ptr_inc(rd_ptr_q);
    cnt_d = cnt_q + 32'(do_wr) - 32'(do_rd);
  end

  assign count = cnt_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end
endmodule

// Sweeps a window of a 1-cycle-latency RAM and streams each word tagged with its address.
// Latency: start in cycle 0, raddr in cycle 1, first beat valid in cycle 3.
// Backpressure: reads issue only while buffered plus in-flight words fit the FIFO.
module mem_readback_streamer #(
  parameter int WID_MEM    = 16,
  parameter int DEPTH_MEM  = 4096,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [31:0]             rd_base,
  input  logic [31:0]             rd_len,
  output logic [31:0]             raddr,
  input  logic [WID_MEM-1:0]      rdata,
  mem_readback_streamer_if.master m_if,
  output logic                    busy,
  output logic                    done,
  output logic [31:0]             checksum
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FINISH} state_t;

  state_t      state_q, state_d;
  logic [31:0] next_addr_q, next_addr_d;
  logic [31:0] last_addr_q, last_addr_d;
  logic [31:0] to_issue_q, to_issue_d;
  logic [31:0] to_accept_q, to_accept_d;
  logic        tag_vld_q, tag_vld_d;
  logic [31:0] tag_addr_q, tag_addr_d;
  logic [31:0] checksum_q, checksum_d;
  logic        busy_q, busy_d, done_q, done_d;
  logic        issue, xfer;

  logic                fifo_wr_vld, fifo_rd_vld;
  logic [WID_MEM+31:0] fifo_wr_dat, fifo_rd_dat;
  logic [31:0]         fifo_cnt;

  // The word read last cycle arrives now and is pushed with its tag.
  assign fifo_wr_vld = tag_vld_q;
  assign fifo_wr_dat = {rdata, tag_addr_q};

  mrs_fifo #(.W(WID_MEM + 32), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .wr_vld (fifo_wr_vld),
    .wr_dat (fifo_wr_dat),
    .rd_vld (fifo_rd_vld),
    .rd_rdy (m_if.m_ready),
    .rd_dat (fifo_rd_dat),
    .count  (fifo_cnt)
  );

  assign m_if.m_valid = fifo_rd_vld;
  assign m_if.m_data  = fifo_rd_dat[WID_MEM+31:32];
  assign m_if.m_addr  = fifo_rd_dat[31:0];

  always_comb begin
    xfer  = fifo_rd_vld && m_if.m_ready;
    issue = (state_q == RUN) && (to_issue_q != 0) &&
            ((fifo_cnt + 32'(tag_vld_q)) < 32'(FIFO_DEPTH));
    raddr = issue ? next_addr_q : last_addr_q;

    state_d     = state_q;
    next_addr_d = next_addr_q;
    last_addr_d = last_addr_q;
    to_issue_d  = to_issue_q;
    to_accept_d = to_accept_q;
    checksum_d  = checksum_q;
    tag_vld_d   = issue;
    tag_addr_d  = issue ? next_addr_q : tag_addr_q;

    if (issue) begin
      last_addr_d = next_addr_q;
      next_addr_d = (next_addr_q == 32'(DEPTH_MEM - 1)) ? '0 : next_addr_q + 1;
      to_issue_d  = to_issue_q - 1;
    end
    if (xfer) begin
      checksum_d  = checksum_q + 32'(m_if.m_data);
      to_accept_d = to_accept_q - 1;
    end

    case (state_q)
      IDLE: if (start) begin
        checksum_d  = '0;
        next_addr_d = rd_base % 32'(DEPTH_MEM);
        to_issue_d  = rd_len;
        to_accept_d = rd_len;
        state_d     = (rd_len == 0) ? FINISH : RUN;
      end
      RUN:    if (issue && to_issue_q == 1) state_d = DRAIN;
      DRAIN:  if (xfer && to_accept_q == 1) state_d = FINISH;
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == RUN) || (state_d == DRAIN);
    done_d = (state_d == FINISH);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      next_addr_q <= '0;
      last_addr_q <= '0;
      to_issue_q  <= '0;
      to_accept_q <= '0;
      tag_vld_q   <= 1'b0;
      tag_addr_q  <= '0;
      checksum_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      next_addr_q <= next_addr_d;
      last_addr_q <= last_addr_d;
      to_issue_q  <= to_issue_d;
      to_accept_q <= to_accept_d;
      tag_vld_q   <= tag_vld_d;
      tag_addr_q  <= tag_addr_d;
      checksum_q  <= checksum_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign checksum = checksum_q;
endmodule

// File: tb/tb_mem_readback_streamer.sv
// Bench for mem_readback_streamer: RAM model, scenario tasks and a queue-based reference.
module tb_mem_readback_streamer;
  localparam int WID   = 16;
  localparam int DEPTH = 4096;
  localparam int FD    = 4;

  logic           clk = 1'b0, reset = 1'b0, start = 1'b0;
  logic [31:0]    rd_base = '0, rd_len = '0;
  logic [31:0]    raddr, checksum;
  logic [WID-1:0] rdata;
  logic           busy, done;
  logic [WID-1:0] ram [DEPTH];
  int errors = 0, checks = 0, cyc = 0;

  mem_readback_streamer_if #(.WID_MEM(WID)) mif ();

  mem_readback_streamer #(.WID_MEM(WID), .DEPTH_MEM(DEPTH), .FIFO_DEPTH(FD)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .rd_base  (rd_base),
    .rd_len   (rd_len),
    .raddr    (raddr),
    .rdata    (rdata),
    .m_if     (mif),
    .busy     (busy),
    .done     (done),
    .checksum (checksum)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    rdata <= ram[raddr[11:0]];
    cyc   <= cyc + 1;
  end

  logic [31:0]    got_addr[$];
  logic [WID-1:0] got_data[$];
  int             got_cyc[$];
  int             done_cyc[$];
  int             first_vld = -1;
  bit             busy_seen = 0;

  // Stall-hold and FIFO-overflow monitor, sampled mid-cycle.
  logic           prev_stall = 1'b0;
  logic [31:0]    prev_addr = '0;
  logic [WID-1:0] prev_data = '0;
  always @(negedge clk) begin
    if (prev_stall) begin
      checks++;
      if (!mif.m_valid || mif.m_addr !== prev_addr || mif.m_data !== prev_data) begin
        errors++;
        $display("FAIL stall_hold: valid=%b addr=%0d data=%0h, required valid=1 addr=%0d data=%0h",
                 mif.m_valid, mif.m_addr, mif.m_data, prev_addr, prev_data);
      end
    end
    if (dut.fifo_wr_vld && dut.fifo_cnt == 32'(FD)) begin
      checks++;
      if (!(mif.m_valid && mif.m_ready)) begin
        errors++;
        $display("FAIL fifo_overflow: write into full FIFO with no read at cycle %0d", cyc);
      end
    end
    prev_stall = reset && mif.m_valid && !mif.m_ready;
    prev_addr  = mif.m_addr;
    prev_data  = mif.m_data;
  end

  function automatic logic [31:0] exp_addr(input logic [31:0] base, input int i);
    return (base + 32'(i)) % 32'(DEPTH);
  endfunction

  task automatic cyc_step(input logic rdy, input logic st);
    @(posedge clk);
    #1;
    start       = st;
    mif.m_ready = rdy;
    if (mif.m_valid && first_vld < 0) first_vld = cyc;
    if (mif.m_valid && rdy) begin
      got_addr.push_back(mif.m_addr);
      got_data.push_back(mif.m_data);
      got_cyc.push_back(cyc);
    end
    if (done) done_cyc.push_back(cyc);
    if (busy) busy_seen = 1;
  endtask

  task automatic clear_log;
    got_addr.delete(); got_data.delete(); got_cyc.delete(); done_cyc.delete();
    first_vld = -1;
    busy_seen = 0;
  endtask

  // mode 0: ready=1; 1: toggling ready with a 10-cycle stall; 2: random ready; 3: ready=1 plus a start while busy
  task automatic run_sweep(input logic [31:0] base, input logic [31:0] len,
                           input int mode, output int s);
    logic rdy, st;
    int n;
    clear_log();
    rd_base = base;
    rd_len  = len;
    cyc_step(1'b1, 1'b1);
    s = cyc;
    n = 0;
    while (done_cyc.size() == 0 && n < 2000) begin
      rdy = 1'b1;
      st  = 1'b0;
      if (mode == 1) rdy = (n >= 6 && n < 16) ? 1'b0 : (n % 2 == 0);
      else if (mode == 2) rdy = 1'($urandom_range(0, 1));
      else if (mode == 3 && n == 4) begin
        rd_base = 100;
        st      = 1'b1;
      end
      cyc_step(rdy, st);
      n++;
    end
    checks++;
    if (done_cyc.size() == 0) begin
      errors++;
      $display("FAIL sweep_timeout: no done within 2000 cycles (base=%0d len=%0d)", base, len);
    end
    repeat (3) cyc_step(1'b1, 1'b0);
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (3) cyc_step(1'b0, 1'b0);
    checks++;
    if ({raddr, mif.m_valid, mif.m_data, mif.m_addr, busy, done, checksum} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: raddr=%0d vld=%b data=%0h addr=%0d busy=%b done=%b sum=%0d, required all 0",
               raddr, mif.m_valid, mif.m_data, mif.m_addr, busy, done, checksum);
    end
    reset = 1'b1;
    cyc_step(1'b0, 1'b0);
  endtask

  task automatic test_stream;
    int s;
    logic [31:0] a, sum;
    run_sweep(0, 8, 0, s);
    checks++;
    if (first_vld != s + 3) begin
      errors++;
      $display("FAIL stream_latency: first valid at start+%0d, required start+3", first_vld - s);
    end
    checks++;
    if (got_addr.size() != 8) begin
      errors++;
      $display("FAIL stream_count: %0d beats, required 8", got_addr.size());
    end
    sum = 0;
    for (int i = 0; i < 8; i++) begin
      a = exp_addr(0, i);
      sum += 32'(ram[a[11:0]]);
      if (i < got_addr.size()) begin
        checks++;
        if (got_addr[i] !== a || got_data[i] !== ram[a[11:0]] || got_cyc[i] != s + 3 + i) begin
          errors++;
          $display("FAIL stream_beat%0d: addr=%0d data=%0h cyc=+%0d, required addr=%0d data=%0h cyc=+%0d",
                   i, got_addr[i], got_data[i], got_cyc[i] - s, a, ram[a[11:0]], 3 + i);
        end
      end
    end
    checks++;
    if (done_cyc.size() != 1 || done_cyc[0] != s + 11) begin
      errors++;
      $display("FAIL stream_done: %0d pulses, first at start+%0d, required 1 at start+11",
               done_cyc.size(), done_cyc.size() ? done_cyc[0] - s : -1);
    end
    checks++;
    if (checksum !== sum) begin
      errors++;
      $display("FAIL stream_checksum: %0d, required %0d", checksum, sum);
    end
  endtask

  task automatic test_zero_len;
    int s;
    run_sweep(5, 0, 0, s);
    checks++;
    if (got_addr.size() != 0 || first_vld != -1 || busy_seen) begin
      errors++;
      $display("FAIL zero_len_activity: beats=%0d valid_seen=%0d busy_seen=%0d, required none",
               got_addr.size(), first_vld, busy_seen);
    end
    checks++;
    if (done_cyc.size() != 1 || done_cyc[0] != s + 1) begin
      errors++;
      $display("FAIL zero_len_done: %0d pulses, first at start+%0d, required 1 at start+1",
               done_cyc.size(), done_cyc.size() ? done_cyc[0] - s : -1);
    end
    checks++;
    if (checksum !== 32'd0) begin
      errors++;
      $display("FAIL zero_len_checksum: %0d, required 0", checksum);
    end
  endtask

  // Shared by backpressure, wrap and busy-start scenarios: beats, done and checksum against the model.
  task automatic test_window(input string name, input logic [31:0] base,
                             input int len, input int mode);
    int s;
    logic [31:0] a, sum;
    run_sweep(base, 32'(len), mode, s);
    checks++;
    if (got_addr.size() != len) begin
      errors++;
      $display("FAIL %s_count: %0d beats, required %0d", name, got_addr.size(), len);
    end
    sum = 0;
    for (int i = 0; i < len; i++) begin
      a = exp_addr(base, i);
      sum += 32'(ram[a[11:0]]);
      if (i < got_addr.size()) begin
        checks++;
        if (got_addr[i] !== a || got_data[i] !== ram[a[11:0]]) begin
          errors++;
          $display("FAIL %s_beat%0d: addr=%0d data=%0h, required addr=%0d data=%0h",
                   name, i, got_addr[i], got_data[i], a, ram[a[11:0]]);
        end
      end
    end
    checks++;
    if (done_cyc.size() != 1 || (len > 0 && got_cyc.size() > 0 && done_cyc[0] != got_cyc[$] + 1)
        || (len == 0 && done_cyc[0] != s + 1)) begin
      errors++;
      $display("FAIL %s_done: %0d pulses, first at start+%0d", name, done_cyc.size(),
               done_cyc.size() ? done_cyc[0] - s : -1);
    end
    checks++;
    if (checksum !== sum) begin
      errors++;
      $display("FAIL %s_checksum: %0d, required %0d", name, checksum, sum);
    end
  endtask

  task automatic test_reset_mid;
    int s, n;
    clear_log();
    rd_base = 0;
    rd_len  = 64;
    cyc_step(1'b1, 1'b1);
    n = 0;
    while (got_addr.size() < 5 && n < 100) begin
      cyc_step(1'b1, 1'b0);
      n++;
    end
    repeat (8) cyc_step(1'b0, 1'b0);
    checks++;
    if (checksum !== 32'd10 || !mif.m_valid) begin
      errors++;
      $display("FAIL reset_mid_pre: checksum=%0d valid=%b, required 10 and 1", checksum, mif.m_valid);
    end
    reset = 1'b0;
    cyc_step(1'b0, 1'b0);
    reset = 1'b1;
    checks++;
    if (mif.m_valid !== 1'b0 || busy !== 1'b0 || checksum !== 32'd0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_outputs: valid=%b busy=%b sum=%0d done=%b, required all 0",
               mif.m_valid, busy, checksum, done);
    end
    repeat (6) cyc_step(1'b1, 1'b0);
    checks++;
    if (done_cyc.size() != 0 || got_addr.size() != 5) begin
      errors++;
      $display("FAIL reset_mid_quiet: done pulses=%0d beats=%0d, required 0 and 5",
               done_cyc.size(), got_addr.size());
    end
    run_sweep(0, 2, 0, s);
    checks++;
    if (got_addr.size() != 2 || got_addr[0] !== 32'd0 || got_addr[1] !== 32'd1 ||
        got_data[0] !== 16'd0 || got_data[1] !== 16'd1 || checksum !== 32'd1) begin
      errors++;
      $display("FAIL reset_mid_restart: beats=%0d checksum=%0d, required beats 0,1 and checksum 1",
               got_addr.size(), checksum);
    end
  endtask

  task automatic test_random;
    logic [31:0] base;
    int len;
    for (int i = 0; i < DEPTH; i++) ram[i] = WID'($urandom);
    for (int k = 0; k < 6; k++) begin
      base = 32'($urandom_range(0, DEPTH - 1));
      len  = (k == 2) ? 0 : int'($urandom_range(1, 40));
      test_window("random", base, len, 2);
    end
  endtask

  initial begin
    mif.m_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) ram[i] = WID'(i);
    test_reset();
    test_stream();
    test_zero_len();
    test_window("backpressure", 0, 16, 1);
    test_window("wrap", 4094, 4, 0);
    test_window("busy_start", 0, 8, 3);
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
